// File: rtl/signal_playback.sv
// Event-list stimulus generator: holds (cycle, value) events and replays them on signal_o,
// cycle-accurately relative to the start edge, once or in a loop.
module signal_playback #(
    parameter int unsigned MAX_ENTRIES = 1000,
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned CYCLE_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_valid_i,
    input  logic [CYCLE_WIDTH-1:0] load_cycle_i,
    input  logic [WIDTH-1:0]       load_value_i,
    output logic                   load_ready_o,
    input  logic [WIDTH-1:0]       init_value_i,
    input  logic                   start_i,
    input  logic                   loop_i,
    input  logic                   stop_i,
    input  logic                   clear_i,
    output logic [WIDTH-1:0]       signal_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CYCLE_WIDTH-1:0] events_o,
    output logic [CYCLE_WIDTH-1:0] cycle_o,
    output logic                   error_o
);

    localparam int unsigned IDX_W = (MAX_ENTRIES > 1) ? $clog2(MAX_ENTRIES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       signal_q, signal_d;
    logic [CYCLE_WIDTH-1:0] events_q, events_d;
    logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   loop_q, loop_d;
    logic                   error_q, error_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   load_ready_q, load_ready_d;

    logic [CYCLE_WIDTH-1:0] stamp_mem [MAX_ENTRIES];
    logic [WIDTH-1:0]       value_mem [MAX_ENTRIES];

    logic                   wr_en_c;
    logic                   full_c;
    logic [IDX_W-1:0]       last_idx_c;
    logic [CYCLE_WIDTH-1:0] last_stamp_c;
    logic [CYCLE_WIDTH-1:0] cur_stamp_c;
    logic [WIDTH-1:0]       cur_value_c;

    assign full_c       = (events_q == CYCLE_WIDTH'(MAX_ENTRIES));
    assign last_idx_c   = IDX_W'(events_q - CYCLE_WIDTH'(1));
    assign last_stamp_c = stamp_mem[last_idx_c];
    assign cur_stamp_c  = stamp_mem[idx_q];
    assign cur_value_c  = value_mem[idx_q];

    // Event storage; contents are meaningless beyond events_q so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (wr_en_c) begin
            stamp_mem[IDX_W'(events_q)] <= load_cycle_i;
            value_mem[IDX_W'(events_q)] <= load_value_i;
        end
    end

    // Next-state: stop > clear > start > load/playback.
    always_comb begin
        state_d  = state_q;
        signal_d = signal_q;
        events_d = events_q;
        cycle_d  = cycle_q;
        idx_d    = idx_q;
        loop_d   = loop_q;
        error_d  = error_q;
        wr_en_c  = 1'b0;

        if (stop_i) begin
            state_d = IDLE;
        end else if (clear_i && (state_q != RUN)) begin
            events_d = '0;
            state_d  = IDLE;
        end else if (start_i && (state_q != RUN) && (events_q != '0)) begin
            state_d  = RUN;
            signal_d = init_value_i;
            cycle_d  = '0;
            idx_d    = '0;
            loop_d   = loop_i;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid_i) begin
                        if (full_c || ((events_q != '0) && (load_cycle_i <= last_stamp_c))) begin
                            error_d = 1'b1;
                        end else begin
                            wr_en_c  = 1'b1;
                            events_d = events_q + CYCLE_WIDTH'(1);
                        end
                    end
                end
                RUN: begin
                    cycle_d = cycle_q + CYCLE_WIDTH'(1);
                    if (cur_stamp_c == cycle_q) begin
                        signal_d = cur_value_c;
                        if (idx_q == last_idx_c) begin
                            if (loop_q) begin
                                idx_d   = '0;
                                cycle_d = '0;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        busy_d       = (state_d == RUN);
        done_d       = (state_d == DONE);
        load_ready_d = (state_d == IDLE) && (events_d != CYCLE_WIDTH'(MAX_ENTRIES));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            signal_q     <= '0;
            events_q     <= '0;
            cycle_q      <= '0;
            idx_q        <= '0;
            loop_q       <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            signal_q     <= signal_d;
            events_q     <= events_d;
            cycle_q      <= cycle_d;
            idx_q        <= idx_d;
            loop_q       <= loop_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign signal_o     = signal_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign events_o     = events_q;
    assign cycle_o      = cycle_q;
    assign error_o      = error_q;
    assign load_ready_o = load_ready_q;

endmodule

// File: tb/tb_signal_playback.sv
// Directed bench for signal_playback: playback timing, replay, looping, stop/clear/reset
// and load rejection, with a small recorder rebuilding the event list from signal_o.
module tb_signal_playback;

    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_valid = 1'b0;
    logic [CW-1:0] load_cycle = '0;
    logic          load_value = 1'b0;
    logic          load_ready;
    logic          init_value = 1'b0;
    logic          start = 1'b0;
    logic          loop = 1'b0;
    logic          stop = 1'b0;
    logic          clear = 1'b0;
    logic          signal;
    logic          busy;
    logic          done;
    logic [CW-1:0] events;
    logic [CW-1:0] cycle;
    logic          error;

    int n_cmp = 0;
    int n_err = 0;

    logic [CW-1:0] rec_c [8];
    logic          rec_v [8];
    int            rec_n;

    signal_playback #(.MAX_ENTRIES(4), .WIDTH(1), .CYCLE_WIDTH(CW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_valid_i (load_valid),
        .load_cycle_i (load_cycle),
        .load_value_i (load_value),
        .load_ready_o (load_ready),
        .init_value_i (init_value),
        .start_i      (start),
        .loop_i       (loop),
        .stop_i       (stop),
        .clear_i      (clear),
        .signal_o     (signal),
        .busy_o       (busy),
        .done_o       (done),
        .events_o     (events),
        .cycle_o      (cycle),
        .error_o      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [CW-1:0] c, input logic v);
        load_valid = 1'b1;
        load_cycle = c;
        load_value = v;
        step();
        load_valid = 1'b0;
    endtask

    // Single run of the (0,1),(3,0),(4,1) list with init 0; bit k = signal after edge E+k.
    task automatic play_once(input string tag);
        logic [5:0] pat;
        logic       prev;
        pat = 6'b101110;
        init_value = 1'b0;
        loop  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy_E"}, 32'(busy), 32'd1);
        chk({tag, "_sig_E"}, 32'(signal), 32'd0);
        rec_n = 0;
        prev  = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("%s_sig_E%0d", tag, k), 32'(signal), 32'(pat[k]));
            if (signal !== prev) begin
                rec_c[rec_n] = CW'(k - 1);
                rec_v[rec_n] = signal;
                rec_n++;
                prev = signal;
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_cycle_end"}, cycle, 32'd5);
        chk({tag, "_rec_n"}, 32'(rec_n), 32'd3);
        chk({tag, "_rec_c0"}, rec_c[0], 32'd0);
        chk({tag, "_rec_v0"}, 32'(rec_v[0]), 32'd1);
        chk({tag, "_rec_c1"}, rec_c[1], 32'd3);
        chk({tag, "_rec_v1"}, 32'(rec_v[1]), 32'd0);
        chk({tag, "_rec_c2"}, rec_c[2], 32'd4);
        chk({tag, "_rec_v2"}, 32'(rec_v[2]), 32'd1);
    endtask

    initial begin
        logic [10:0] lpat;

        step();
        step();
        rst = 1'b0;
        chk("rst_signal", 32'(signal), 32'd0);
        chk("rst_events", events, 32'd0);
        chk("rst_cycle", cycle, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd1);

        // Basic run, then replay from DONE without reloading.
        load(32'd0, 1'b1);
        load(32'd3, 1'b0);
        load(32'd4, 1'b1);
        chk("load_events", events, 32'd3);
        play_once("run1");
        play_once("replay");

        // Loop mode; a load during RUN must be ignored without error.
        lpat  = 11'b10111101110;
        loop  = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        loop  = 1'b0;
        chk("loop_sig_E", 32'(signal), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            if (k == 2) load_valid = 1'b1;
            step();
            load_valid = 1'b0;
            chk($sformatf("loop_sig_E%0d", k), 32'(signal), 32'(lpat[k]));
            if (k == 6) chk("loop_cycle_E6", cycle, 32'd1);
        end
        chk("loop_done", 32'(done), 32'd0);
        chk("loop_busy", 32'(busy), 32'd1);
        chk("loop_events", events, 32'd3);
        chk("loop_err", 32'(error), 32'd0);
        // Stop on the edge that would otherwise drive 1: signal must hold 0.
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        chk("stop_sig_hold", 32'(signal), 32'd0);
        chk("stop_events", events, 32'd3);
        play_once("after_stop");

        // Clear from DONE, then start with nothing loaded.
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_events", events, 32'd0);
        chk("clear_done", 32'(done), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("empty_start_busy", 32'(busy), 32'd0);

        // Reset mid-run.
        load(32'd0, 1'b1);
        load(32'd2, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("pre_rst_sig", 32'(signal), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_sig", 32'(signal), 32'd0);
        chk("midrst_events", events, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cycle", cycle, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("midrst_start_busy", 32'(busy), 32'd0);

        // Non-increasing stamps are dropped.
        load(32'd5, 1'b1);
        load(32'd2, 1'b0);
        chk("order_events", events, 32'd1);
        chk("order_err", 32'(error), 32'd1);
        load(32'd5, 1'b0);
        chk("equal_events", events, 32'd1);

        // Fill to capacity, then overflow.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_err", 32'(error), 32'd0);
        load(32'd1, 1'b0);
        load(32'd2, 1'b1);
        load(32'd3, 1'b0);
        chk("ready_3", 32'(load_ready), 32'd1);
        load(32'd4, 1'b1);
        chk("full_ready", 32'(load_ready), 32'd0);
        chk("full_events", events, 32'd4);
        chk("full_err_pre", 32'(error), 32'd0);
        load(32'd5, 1'b1);
        chk("ovf_events", events, 32'd4);
        chk("ovf_err", 32'(error), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
